// File: rtl/shift_sequencer.sv
// Multi-cycle register-specified shifter: STEP bits per cycle, ARM carry.
// Ports: clk_i, rst_i (sync, active-high), start_i, shift_type_i[1:0]
//   (00 LSL/01 LSR/10 ASR/11 ROR), shift_amt_i[7:0], operand_i, carry_in_i,
//   flush_i -> ready_o, busy_o, done_o, result_o, carry_out_o.
// Option: define SHIFT_SEQ_FASTPATH_EN to resolve LSL/LSR/ASR with an
//   amount >= DATA_LEN in the accept cycle (IDLE -> DONE, no busy).
module shift_sequencer #(
    parameter int DATA_LEN = 32,
    parameter int STEP     = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [1:0]          shift_type_i,
    input  logic [7:0]          shift_amt_i,
    input  logic [DATA_LEN-1:0] operand_i,
    input  logic                carry_in_i,
    input  logic                flush_i,
    output logic                ready_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [DATA_LEN-1:0] result_o,
    output logic                carry_out_o
);

    localparam logic [8:0]  LIM_LS = 9'(DATA_LEN + 1);
    localparam logic [8:0]  LIM_AS = 9'(DATA_LEN);
    localparam logic [5:0]  STEP_C = 6'(STEP);
    localparam logic [31:0] DL_W   = 32'(DATA_LEN);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [DATA_LEN-1:0] data_q, data_d;
    logic [DATA_LEN-1:0] result_q, result_d;
    logic                carry_q, carry_d;
    logic                cout_q, cout_d;
    logic [1:0]          type_q, type_d;
    logic [5:0]          cnt_q, cnt_d;

    logic                accept;
    logic [8:0]          amt9;
    logic [5:0]          n_s;
    logic                c0_s;
    logic                fast_s;
    logic [DATA_LEN-1:0] fres_s;
    logic                fc_s;

    assign accept = (state_q == S_IDLE) && start_i && !flush_i;

    // Effective count and the carry seen when nothing gets shifted.
    always_comb begin
        amt9   = {1'b0, shift_amt_i};
        n_s    = '0;
        c0_s   = carry_in_i;
        fast_s = 1'b0;
        fres_s = '0;
        fc_s   = 1'b0;
        unique case (shift_type_i)
            2'b00, 2'b01: n_s = 6'((amt9 > LIM_LS) ? LIM_LS : amt9);
            2'b10:        n_s = 6'((amt9 > LIM_AS) ? LIM_AS : amt9);
            default: begin
                n_s = {1'b0, shift_amt_i[4:0]};
                // ROR by a nonzero multiple of 32 still reports bit 31.
                if (shift_amt_i != 8'd0 && shift_amt_i[4:0] == 5'd0)
                    c0_s = operand_i[DATA_LEN-1];
            end
        endcase
`ifdef SHIFT_SEQ_FASTPATH_EN
        if (shift_type_i != 2'b11 && amt9 >= LIM_AS) begin
            fast_s = 1'b1;
            unique case (shift_type_i)
                2'b00:   fc_s = (amt9 == LIM_AS) & operand_i[0];
                2'b01:   fc_s = (amt9 == LIM_AS) & operand_i[DATA_LEN-1];
                default: begin
                    fres_s = {DATA_LEN{operand_i[DATA_LEN-1]}};
                    fc_s   = operand_i[DATA_LEN-1];
                end
            endcase
        end
`endif
    end

    // One datapath step of k bits; the extra bit in ext catches the carry.
    logic [5:0]          k;
    logic [DATA_LEN:0]   ext;
    logic [DATA_LEN-1:0] step_r;
    logic                step_c;

    always_comb begin
        k      = (cnt_q > STEP_C) ? STEP_C : cnt_q;
        ext    = '0;
        step_r = data_q;
        step_c = carry_q;
        unique case (type_q)
            2'b00: begin
                ext    = {1'b0, data_q} << k;
                step_r = ext[DATA_LEN-1:0];
                step_c = ext[DATA_LEN];
            end
            2'b01: begin
                ext    = {data_q, 1'b0} >> k;
                step_r = ext[DATA_LEN:1];
                step_c = ext[0];
            end
            2'b10: begin
                ext    = $signed({data_q, 1'b0}) >>> k;
                step_r = ext[DATA_LEN:1];
                step_c = ext[0];
            end
            default: begin
                step_r = (data_q >> k) | (data_q << (DL_W - 32'(k)));
                step_c = step_r[DATA_LEN-1];
            end
        endcase
    end

    // State register and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            type_q   <= 2'b00;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            type_q   <= type_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = (fast_s || n_s == 6'd0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                if (flush_i)
                    state_d = S_IDLE;
                else if (cnt_q <= STEP_C)
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; result only updates on a completed operation.
    always_comb begin
        data_d   = data_q;
        carry_d  = carry_q;
        type_d   = type_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d  = operand_i;
                    carry_d = c0_s;
                    type_d  = shift_type_i;
                    cnt_d   = n_s;
                    if (fast_s) begin
                        cnt_d    = '0;
                        result_d = fres_s;
                        cout_d   = fc_s;
                    end else if (n_s == 6'd0) begin
                        result_d = operand_i;
                        cout_d   = c0_s;
                    end
                end
            end
            S_SHIFT: begin
                if (!flush_i) begin
                    data_d  = step_r;
                    carry_d = step_c;
                    cnt_d   = cnt_q - k;
                    if (cnt_q <= STEP_C) begin
                        result_d = step_r;
                        cout_d   = step_c;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        ready_o     = (state_q == S_IDLE);
        busy_o      = (state_q == S_SHIFT);
        done_o      = (state_q == S_DONE);
        result_o    = result_q;
        carry_out_o = cout_q;
    end

endmodule
